// File: rtl/pcler_param.sv
// Loadable up/down counter slice with auto-reload on terminal count, sticky
// overflow and cascade carry (tc -> next stage cin).
module pcler_param #(
  parameter int unsigned          WIDTH   = 8,
  parameter logic [WIDTH-1:0]     RST_RLD = '0
) (
  input  logic             clk_i,
  input  logic             rst_n_i,
  input  logic             load_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             en_i,
  input  logic             hold_i,
  input  logic             cin_i,
  input  logic             up_i,
  input  logic             rld_we_i,
  input  logic [WIDTH-1:0] rld_d_i,
  input  logic             clr_ovf_i,
  output logic [WIDTH-1:0] q_o,
  output logic             tc_o,
  output logic             tc_q_o,
  output logic             ovf_o,
  output logic [WIDTH-1:0] rld_q_o
);

  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] rld_q, rld_d;
  logic             tc_q, tc_d;
  logic             ovf_q, ovf_d;
  logic             step, at_term, tc;

  // load outranks counting, so it also masks the terminal-count event
  assign step    = en_i & ~hold_i & cin_i & ~load_i;
  assign at_term = up_i ? (q_q == {WIDTH{1'b1}}) : (q_q == '0);
  assign tc      = step & at_term;

  always_comb begin
    q_d = q_q;
    if (load_i)     q_d = d_i;
    else if (tc)    q_d = rld_q;  // old reload value even if rld_we_i is high
    else if (step)  q_d = up_i ? q_q + 1'b1 : q_q - 1'b1;
  end

  always_comb begin
    rld_d = rld_we_i ? rld_d_i : rld_q;
    tc_d  = tc;
    ovf_d = tc | (ovf_q & ~clr_ovf_i);
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      q_q   <= '0;
      rld_q <= RST_RLD;
      tc_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      rld_q <= rld_d;
      tc_q  <= tc_d;
      ovf_q <= ovf_d;
    end
  end

  assign q_o     = q_q;
  assign tc_o    = tc;
  assign tc_q_o  = tc_q;
  assign ovf_o   = ovf_q;
  assign rld_q_o = rld_q;

endmodule

// File: doc/pcler_param.md
# pcler_param

Parametrised synchronous loadable up/down counter with auto-reload on terminal count. It is the registered, width-generic successor to the team's 8-bit combinational count/load next-state block (`pcler8`). It holds its own count and reload registers and adds a down-count mode. It also provides cascade carry-in, a registered terminal-count pulse and a sticky overflow flag. It is used as a timer/prescaler slice in the control datapath and can be chained through `tc`/`cin`.

## Interface
- `WIDTH`, 8: counter, load and reload width; legal range 2..32.
- `RST_RLD`, 0: reset value of the reload register, WIDTH bits.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  reset, asynchronous and active-low; clears all state.
- `load`  in  1  synchronous parallel load of `d`; highest priority.
- `d`  in  WIDTH  parallel load data.
- `en`  in  1  count enable.
- `hold`  in  1  count inhibit; overrides `en`.
- `cin`  in  1  cascade carry-in; tie to 1 when not chained.
- `up`  in  1  1 = count up, 0 = count down.
- `rld_we`  in  1  write `rld_d` into the reload register.
- `rld_d`  in  WIDTH  reload register write data.
- `clr_ovf`  in  1  clear the sticky overflow flag.
- `q`  out  WIDTH  current count (register output).
- `tc`  out  1  combinational terminal count; feeds the next stage's `cin`.
- `tc_q`  out  1  `tc` registered; one-cycle pulse.
- `ovf`  out  1  sticky flag; set by any terminal-count event.
- `rld_q`  out  WIDTH  current reload register value.

## Operation
- Effective step: `step = en & ~hold & cin & ~load`.
- Terminal count:
  - `tc = step & (up ? q == all-ones : q == 0)`.
  - `tc` is purely combinational from `q` and the inputs.
- Next count, by priority:
  1. `load` gives `d`.
  2. `tc` gives `rld_q`. This is a reload, not a wrap.
  3. `step & up` gives `q+1`.
  4. `step & ~up` gives `q-1`.
  5. Otherwise `q` holds.
- Arithmetic is modulo 2^WIDTH. Wrap never occurs while stepping, because the terminal value always reloads. A natural wrap appears only when `rld_q` equals the wrap value, e.g. `rld_q=0` with up-count.
- Reload register:
  - On `rld_we`, `rld_q <= rld_d`.
  - A reload in the same cycle uses the old `rld_q`; the new value applies from the next edge.
- `tc_q <= tc` on every edge.
- Overflow flag:
  - `ovf <= tc | (ovf & ~clr_ovf)`.
  - If `tc` and `clr_ovf` occur in the same cycle, set wins.
- `load` suppresses `tc`, so a load on a terminal value neither reloads nor sets `ovf`.
- `up` may change on any cycle; it takes effect on the next edge with no pipeline.

## Timing
- Reset values, asserted asynchronously and released synchronously by the user:
  - `q=0`, `rld_q=RST_RLD`, `tc_q=0`, `ovf=0`.
  - `tc` then follows its equation; e.g. `up=0`, `step=1` right after reset gives `tc=1`.
- Latency:
  - `load`, `rld_we`, count and reload each take 1 cycle to show on `q`/`rld_q`.
  - `tc_q` and `ovf` lag `tc` by 1 cycle.
- Cascade: stage k's `tc` drives stage k+1's `cin`, all clocked by the same `clk`. The combinational ripple path grows with depth and is the user's timing concern.
- Reset asserted mid-count clears all state immediately. The first count after release starts from `q=0`.
- `hold=1` freezes `q` and forces `tc=0`. `load` is still honoured during `hold`.

## Test plan
- Reset, then `up=1`, `en=cin=1`, `rld_q=0xF0` (WIDTH=8):
  - `q` counts to 0xFF; `tc=1` on the 0xFF cycle.
  - Next cycle: `q=0xF0`, `tc_q=1`, `ovf=1`.
- `up=0`, load `d=0x03`, count:
  - `q` goes 0x03, 0x02, 0x01, 0x00; `tc=1` at 0x00.
  - Next `q=rld_q`; `ovf` set.
- Simultaneous events at `q=0xFF` with `up=1`:
  - `rld_we` with `rld_d=0x10`, old `rld_q=0x20`, gives `q=0x20` and `rld_q=0x10`.
  - `clr_ovf=1` in the same cycle leaves `ovf=1`.
- `load=1`, `d=0x55` with `q=0xFF`, `step` otherwise true:
  - `tc=0`; `q=0x55` next cycle; `ovf` unchanged.
- Two stages of WIDTH=4 cascaded via `tc`→`cin`, both `rld=0`, `up=1`:
  - The pair behaves as an 8-bit counter.
  - The high stage advances only on cycles where the low stage has `q=0xF`.
- `hold=1` mid-count freezes `q` and keeps `tc=0`.
- `rst_n` low asserted between clock edges clears `q`, `ovf` and `tc_q` immediately, without waiting for an edge.
